// File: rtl/bet_controller.sv
// -----------------------------------------------------------------------------
// bet_controller
// Sequences one betting round: accepts and validates a bet, escrows the stake
// from the balance, pulses start_round to the game sequencer, waits for the
// round result, settles the payout into the balance and re-opens betting.
//
// Optional feature macro: BACCARAT_WAIT_TIMEOUT_EN
//   Defined   - WAIT gives up after TIMEOUT_CYCLES edges without round_done and
//               settles the round as VOID (stake refunded).
//   Undefined - WAIT holds until round_done.
//
// Handshake: bet_confirm is a level sampled on every edge in BET; round_done is
// a level sampled on every edge in WAIT and the win lights are taken on that
// same edge. There is no back-pressure: start_round and updatebalanceenable are
// single-cycle Moore pulses the consumer must take when they are high.
//
// Ports:
//   slow_clock           in   clock, all state changes on the rising edge
//   resetb               in   asynchronous active-low reset
//   bet_amount[BAL_W]    in   requested stake
//   bet_side[2]          in   01 player, 10 dealer, 11 tie, 00 invalid
//   bet_confirm          in   confirm request (level)
//   round_done           in   winner lights valid
//   player_win           in   player win light
//   dealer_win           in   dealer win light
//   betenabled           out  high in BET
//   start_round          out  one-cycle pulse in DEAL
//   updatebalanceenable  out  one-cycle pulse in SETTLE
//   balance[BAL_W]       out  current balance (registered)
//   bet_error            out  last confirm was rejected
//   broke                out  high in BROKE
//   o_dbg_state[3]       out  FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module bet_controller #(
    parameter int BAL_W          = 8,
    parameter int INIT_BALANCE   = 50,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic [BAL_W-1:0] bet_amount,
    input  logic [1:0]       bet_side,
    input  logic             bet_confirm,
    input  logic             round_done,
    input  logic             player_win,
    input  logic             dealer_win,
    output logic             betenabled,
    output logic             start_round,
    output logic             updatebalanceenable,
    output logic [BAL_W-1:0] balance,
    output logic             bet_error,
    output logic             broke,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_BET    = 3'd0,
        S_DEAL   = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_BROKE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OUT_VOID   = 2'd0,
        OUT_PLAYER = 2'd1,
        OUT_DEALER = 2'd2,
        OUT_TIE    = 2'd3
    } outcome_t;

    localparam int SUM_W = BAL_W + 4;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [BAL_W-1:0]   r_balance;
    logic [BAL_W-1:0]   r_stake;
    logic [1:0]         r_side;
    logic               r_bet_error;

    logic               w_bet_valid;
    logic               w_accept;
    logic               w_timeout;
    logic               w_wait_exit;
    outcome_t           w_outcome;
    logic [SUM_W-1:0]   w_stake_x;
    logic [SUM_W-1:0]   w_credit;
    logic [SUM_W-1:0]   w_sum;
    logic [BAL_W-1:0]   w_settle_bal;

    assign w_bet_valid = (bet_amount != '0) && (bet_amount <= r_balance) && (bet_side != 2'b00);
    assign w_accept    = (r_state == S_BET) && bet_confirm && w_bet_valid;

`ifdef BACCARAT_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // WAIT is only ever entered from DEAL, so clearing in DEAL is "clear on entry".
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_DEAL) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Expires on the TIMEOUT_CYCLES-th edge spent in WAIT.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_wait_exit = (r_state == S_WAIT) && (round_done || w_timeout);

    // A timeout without round_done leaves the outcome VOID; if round_done
    // arrives on the expiry edge the real lights are used.
    always_comb begin
        w_outcome = OUT_VOID;
        if (round_done) begin
            case ({player_win, dealer_win})
                2'b11:   w_outcome = OUT_TIE;
                2'b10:   w_outcome = OUT_PLAYER;
                2'b01:   w_outcome = OUT_DEALER;
                default: w_outcome = OUT_VOID;
            endcase
        end
    end

    // Credit on top of a balance that already has the stake deducted.
    assign w_stake_x = {{4{1'b0}}, r_stake};

    always_comb begin
        w_credit = '0;
        case (w_outcome)
            OUT_VOID:   w_credit = w_stake_x;
            OUT_PLAYER: if (r_side == 2'b01) w_credit = w_stake_x << 1;
            OUT_DEALER: if (r_side == 2'b10) w_credit = w_stake_x << 1;
            OUT_TIE: begin
                if (r_side == 2'b11) begin
                    w_credit = (w_stake_x << 3) + w_stake_x;
                end else if (r_side != 2'b00) begin
                    w_credit = w_stake_x;
                end
            end
            default: w_credit = '0;
        endcase
    end

    assign w_sum        = {{4{1'b0}}, r_balance} + w_credit;
    assign w_settle_bal = (|w_sum[SUM_W-1:BAL_W]) ? {BAL_W{1'b1}} : w_sum[BAL_W-1:0];

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_BET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next              = r_state;
        betenabled          = 1'b0;
        start_round         = 1'b0;
        updatebalanceenable = 1'b0;
        broke               = 1'b0;
        case (r_state)
            S_BET: begin
                betenabled = 1'b1;
                if (w_accept) w_next = S_DEAL;
            end
            S_DEAL: begin
                start_round = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_exit) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                updatebalanceenable = 1'b1;
                w_next = (r_balance != '0) ? S_BET : S_BROKE;
            end
            S_BROKE: begin
                broke = 1'b1;
            end
            default: w_next = S_BET;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_balance   <= BAL_W'(INIT_BALANCE);
            r_stake     <= '0;
            r_side      <= 2'b00;
            r_bet_error <= 1'b0;
        end else begin
            case (r_state)
                S_BET: begin
                    if (bet_confirm) begin
                        if (w_bet_valid) begin
                            r_stake     <= bet_amount;
                            r_side      <= bet_side;
                            r_balance   <= r_balance - bet_amount;
                            r_bet_error <= 1'b0;
                        end else begin
                            r_bet_error <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_wait_exit) r_balance <= w_settle_bal;
                end
                S_BROKE: begin
                    r_balance <= '0;
                end
                default: ;
            endcase
        end
    end

    assign balance     = r_balance;
    assign bet_error   = r_bet_error;
    assign o_dbg_state = r_state;

endmodule

// File: doc/bet_controller.md
Name: bet_controller

Overview:
Sequences one betting round around the card datapath and game state machine. It accepts and validates a bet, escrows it from the balance and pulses a start to the game sequencer. It then waits for the round result, settles the payout into the balance and re-opens betting. It drives betenabled, updatebalanceenable and balance toward the top level, so balance display and round gating live in one sequential block.

Parameters:
BAL_W, 8, width of balance and bet_amount
INIT_BALANCE, 50, balance loaded on reset
TIMEOUT_CYCLES, 64, slow_clock edges allowed in WAIT (used only with the optional feature)

Ports:
slow_clock  in  1  single clock; all state changes on its rising edge
resetb  in  1  asynchronous, active-low reset
bet_amount  in  BAL_W  requested stake
bet_side  in  2  01 player, 10 dealer, 11 tie, 00 invalid
bet_confirm  in  1  level, sampled each edge in BET
round_done  in  1  high for at least one edge when the winner lights are valid
player_win  in  1  player win light
dealer_win  in  1  dealer win light
betenabled  out  1  high in BET
start_round  out  1  one-cycle pulse, high in DEAL
updatebalanceenable  out  1  one-cycle pulse, high in SETTLE
balance  out  BAL_W  current balance (registered)
bet_error  out  1  last confirm was rejected
broke  out  1  high in BROKE

Behaviour:
- All outputs are registered or decoded from state only (Moore). No combinational input-to-output path.
- Reset (resetb low, asynchronous): state=BET, balance=INIT_BALANCE, latched bet and side=0, bet_error=0. Derived outputs: betenabled=1, start_round=0, updatebalanceenable=0, broke=0.
- Reset mid-round discards any escrowed stake; balance returns to INIT_BALANCE.
- BET:
  - bet_confirm=0: hold.
  - bet_confirm=1, valid bet: latch amount and side, balance -= amount, bet_error=0, go to DEAL.
  - Valid means bet_amount!=0, bet_amount<=balance, and bet_side!=00.
  - bet_confirm=1, invalid bet: bet_error=1, stay in BET, balance unchanged. bet_error holds until the next confirm.
- DEAL: start_round=1 for exactly one cycle, then unconditionally go to WAIT. round_done is ignored in DEAL.
- WAIT: on an edge with round_done=1, latch the outcome and go to SETTLE. Otherwise hold.
- Outcome decode:
  - player_win&dealer_win: TIE
  - player only: PLAYER
  - dealer only: DEALER
  - neither: VOID
- SETTLE: updatebalanceenable=1 for one cycle. Credit to balance (stake A is already deducted):
  - Side matches PLAYER/DEALER: +2A.
  - Side tie and outcome TIE: +9A.
  - Side player/dealer and outcome TIE: +A (push).
  - Outcome VOID: +A.
  - Otherwise: +0.
- Settle arithmetic: compute in BAL_W+4 bits and saturate the result to 2^BAL_W-1.
- Exit from SETTLE: go to BET if the new balance is nonzero, else go to BROKE.
- BROKE: broke=1, betenabled=0, balance=0. All inputs are ignored until reset.
- Latency: confirm edge → start_round high in the next cycle. round_done edge → updatebalanceenable high in the next cycle, with the new balance visible in the same cycle. Back in BET one cycle later.

Optional Feature:
Macro BACCARAT_WAIT_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each edge in WAIT. If TIMEOUT_CYCLES edges pass without round_done, force outcome VOID and go to SETTLE, which refunds the stake. round_done on the same edge as expiry wins, and the real outcome is used.
- Undefined: no counter, and WAIT holds indefinitely.

Test Plan:
- Basic win: reset → balance=50, betenabled=1. Apply amount=10, side=01, confirm → balance=40, start_round pulse next cycle. Then round_done with player_win=1 → updatebalanceenable pulse with balance=60, betenabled=1 one cycle later.
- Overbet: with balance=50, apply amount=60, side=01, confirm → bet_error=1, balance=50, state stays BET, no start_round. Then amount=5 → bet_error=0.
- Tie bet and push: amount=20, side=11, tie outcome → balance 30 then 210. Then amount=10, side=10, tie outcome → 200 then 210.
- Saturation: balance=200, amount=100, side=11, tie outcome → balance 100 then 255 (not 1000).
- Broke: balance=50, amount=50, side=10, player wins → balance=0, broke=1, betenabled=0, confirms ignored. resetb low → balance=50 asynchronously, before the next clock edge.
- Timeout, with the macro defined and TIMEOUT_CYCLES=4: bet 10, no round_done for 4 edges → settle VOID, balance back to 50. Without the macro, 100 edges pass and the state stays WAIT with balance=40.
